// File: rtl/lamp_phase_timer_if.sv
// Signal bundle between the lamp phase timer and its controller.
// The slave side is the timer; the master side drives enable and requests.
interface lamp_phase_timer_if #(
  parameter int CNT_W = 8
);
  logic             enable;
  logic             ped_req;
  logic [1:0]       phase;
  logic             advance;
  logic [CNT_W-1:0] remaining;
  logic             ped_ack;
  logic             ped_walk;

  modport master (
    output enable,
    output ped_req,
    input  phase,
    input  advance,
    input  remaining,
    input  ped_ack,
    input  ped_walk
  );

  modport slave (
    input  enable,
    input  ped_req,
    output phase,
    output advance,
    output remaining,
    output ped_ack,
    output ped_walk
  );
endinterface

// File: rtl/lamp_phase_timer.sv
// Programmable-duration red/green/yellow phase timer with a pedestrian
// request handshake that can cut green short and grants walk in the next red.
module lamp_phase_timer #(
  parameter int CNT_W        = 8,
  parameter int RED_TICKS    = 5,
  parameter int GREEN_TICKS  = 4,
  parameter int YELLOW_TICKS = 2,
  parameter int MIN_GREEN    = 2
) (
  input logic               clk,
  input logic               rst,
  lamp_phase_timer_if.slave bus
);

  typedef enum logic [1:0] {
    PH_RED    = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_BAD    = 2'd3
  } phase_e;

  localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_TICKS - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] MIN_ELAPSED = CNT_W'(MIN_GREEN - 1);

  phase_e           phase_q,     phase_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             advance_q,   advance_d;
  logic             ped_ack_q,   ped_ack_d;
  logic             ped_walk_q,  ped_walk_d;
  logic             pending_q,   pending_d;
  logic             served_q,    served_d;

  logic [CNT_W-1:0] green_elapsed;
  logic             truncate;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= PH_RED;
      remaining_q <= RED_LAST;
      advance_q   <= 1'b0;
      ped_ack_q   <= 1'b0;
      ped_walk_q  <= 1'b0;
      pending_q   <= 1'b0;
      served_q    <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      remaining_q <= remaining_d;
      advance_q   <= advance_d;
      ped_ack_q   <= ped_ack_d;
      ped_walk_q  <= ped_walk_d;
      pending_q   <= pending_d;
      served_q    <= served_d;
    end
  end

  // Ticks already spent in green; remaining never exceeds GREEN_LAST there.
  assign green_elapsed = GREEN_LAST - remaining_q;
  assign truncate      = pending_q && (green_elapsed >= MIN_ELAPSED);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    phase_d     = phase_q;
    remaining_d = remaining_q;
    advance_d   = 1'b0;
    ped_ack_d   = 1'b0;
    ped_walk_d  = ped_walk_q;
    pending_d   = pending_q;
    served_d    = served_q;

    if (bus.ped_req && !pending_q) begin
      pending_d = 1'b1;
      ped_ack_d = 1'b1;
    end

    if (phase_q == PH_BAD) begin
      phase_d     = PH_RED;
      remaining_d = RED_LAST;
      advance_d   = 1'b1;
    end else if (bus.enable) begin
      case (phase_q)
        PH_RED: begin
          if (remaining_q == '0) begin
            phase_d     = PH_GREEN;
            remaining_d = GREEN_LAST;
            advance_d   = 1'b1;
            ped_walk_d  = 1'b0;
          end else begin
            remaining_d = remaining_q - 1'b1;
          end
        end
        PH_GREEN: begin
          if (remaining_q == '0 || truncate) begin
            phase_d     = PH_YELLOW;
            remaining_d = YELLOW_LAST;
            advance_d   = 1'b1;
            // A request pending at green exit is handed to the next red.
            if (pending_q) begin
              pending_d = 1'b0;
              served_d  = 1'b1;
            end
          end else begin
            remaining_d = remaining_q - 1'b1;
          end
        end
        PH_YELLOW: begin
          if (remaining_q == '0) begin
            phase_d     = PH_RED;
            remaining_d = RED_LAST;
            advance_d   = 1'b1;
            if (served_q) begin
              ped_walk_d = 1'b1;
              served_d   = 1'b0;
            end
          end else begin
            remaining_d = remaining_q - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.phase     = phase_q;
  assign bus.remaining = remaining_q;
  assign bus.advance   = advance_q;
  assign bus.ped_ack   = ped_ack_q;
  assign bus.ped_walk  = ped_walk_q;

endmodule

// File: tb/tb_lamp_phase_timer.sv
// Directed and randomized bench for lamp_phase_timer against a tick-count
// reference model of the phase/pedestrian rules.
module tb_lamp_phase_timer;

  localparam int CNT_W        = 8;
  localparam int RED_TICKS    = 5;
  localparam int GREEN_TICKS  = 4;
  localparam int YELLOW_TICKS = 2;
  localparam int MIN_GREEN    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  lamp_phase_timer_if #(.CNT_W(CNT_W)) bus ();

  lamp_phase_timer #(
    .CNT_W       (CNT_W),
    .RED_TICKS   (RED_TICKS),
    .GREEN_TICKS (GREEN_TICKS),
    .YELLOW_TICKS(YELLOW_TICKS),
    .MIN_GREEN   (MIN_GREEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: phase index plus ticks completed in that phase.
  int dur [3] = '{RED_TICKS, GREEN_TICKS, YELLOW_TICKS};
  int m_phase;
  int m_done;
  bit m_pending, m_served, m_walk, m_adv, m_ack;

  function automatic void model_reset();
    m_phase   = 0;
    m_done    = 0;
    m_pending = 0;
    m_served  = 0;
    m_walk    = 0;
    m_adv     = 0;
    m_ack     = 0;
  endfunction

  function automatic void model_step(input bit en, input bit req);
    bit was_pending = m_pending;
    bit leave       = 0;
    m_adv = 0;
    m_ack = 0;
    if (en) begin
      m_done++;
      if (m_done == dur[m_phase]) leave = 1;
      if (m_phase == 1 && was_pending && m_done >= MIN_GREEN) leave = 1;
      if (leave) begin
        if (m_phase == 1 && was_pending) begin
          m_pending = 0;
          m_served  = 1;
        end
        if (m_phase == 2 && m_served) begin
          m_walk   = 1;
          m_served = 0;
        end
        if (m_phase == 0) m_walk = 0;
        m_phase = (m_phase + 1) % 3;
        m_done  = 0;
        m_adv   = 1;
      end
    end
    if (req && !was_pending) begin
      m_pending = 1;
      m_ack     = 1;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("phase",     32'(bus.phase),     32'(m_phase));
    check("remaining", 32'(bus.remaining), 32'(dur[m_phase] - 1 - m_done));
    check("advance",   32'(bus.advance),   32'(m_adv));
    check("ped_ack",   32'(bus.ped_ack),   32'(m_ack));
    check("ped_walk",  32'(bus.ped_walk),  32'(m_walk));
  endtask

  // Called at a falling edge; inputs settle before the next rising edge.
  task automatic cycle(input bit en, input bit req);
    bus.enable  = en;
    bus.ped_req = req;
    @(posedge clk);
    model_step(en, req);
    @(negedge clk);
    check_all();
  endtask

  // Asserts reset between clock edges and checks it took effect without one.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.enable  = 1'b0;
    bus.ped_req = 1'b0;
    do_reset();

    // Free-running, two full periods.
    for (int i = 0; i < 22; i++) cycle(1'b1, 1'b0);

    // Enable toggling: durations double, counts freeze while disabled.
    for (int i = 0; i < 24; i++) cycle(i % 2 == 0, 1'b0);

    // Request pulse in red cycle 1: short green, walk through next red.
    do_reset();
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 17; i++) cycle(1'b1, 1'b0);

    // Request held high for 20 cycles.
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);

    // Request on the final green edge: served in the following green.
    do_reset();
    for (int i = 0; i < RED_TICKS + GREEN_TICKS - 1; i++) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 24; i++) cycle(1'b1, 1'b0);

    // Asynchronous reset in the middle of yellow.
    do_reset();
    for (int i = 0; i < RED_TICKS + GREEN_TICKS + 1; i++) cycle(1'b1, 1'b0);
    check("mid_yellow_phase", 32'(bus.phase), 32'd2);
    do_reset();
    check("restart_remaining", 32'(bus.remaining), 32'(RED_TICKS - 1));
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0);

    // Randomized enable and request traffic.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
